cell_fetch: RTL and testbench
=============================

# cell_fetch

Pixel-to-cell lookup stage directly upstream of `cell_render`. It takes the raw VGA counters, maps each pixel to its board cell and reads the packed board memory. It then presents `is_alive_out` together with `hcount_out`/`vcount_out`, delayed so that all three stay aligned for the renderer. It also owns the double-buffered board bank select and swaps banks with the life engine at frame boundaries.

## Interface
Parameters:
- `SCREEN_WIDTH`, 1024: active pixels per line.
- `SCREEN_HEIGHT`, 768: active lines per frame.
- `CELL_LOG`, 3: log2 of cell edge in pixels, giving 8×8-pixel cells.
- `WORD_W`, 16: cells per board memory word.

Ports:
- `clk_in` input 1: pixel clock, the only clock.
- `rst_in` input 1: asynchronous, active-high reset.
- `hcount_in` input 11: pixel column from VGA timing.
- `vcount_in` input 10: pixel row from VGA timing.
- `rd_addr_out` output 11: board RAM read address, `{bank, row[6:0], wordcol[2:0]}`.
- `rd_data_in` input WORD_W: board RAM data. Fixed 2-cycle read latency.
- `swap_req_in` input 1: life engine has finished writing the back bank.
- `swap_ack_out` output 1: one-cycle pulse; the swap has been taken.
- `display_bank_out` output 1: bank currently displayed. The engine writes the other bank.
- `is_alive_out` output 1: cell state for the pixel at `hcount_out`/`vcount_out`.
- `hcount_out` output 11: `hcount_in` delayed by 4 cycles.
- `vcount_out` output 10: `vcount_in` delayed by 4 cycles.

## Operation
- Cell coordinates: `col = hcount_in >> CELL_LOG` (0..127) and `row = vcount_in >> CELL_LOG` (0..95).
- `wordcol = col / WORD_W` and `bit = col % WORD_W`. Bit 0 of a word is the leftmost cell.
- Board rows are stored one per 8-word stripe. Addresses 768..1023 of each bank are unused.
- Active-area gate: `active = (hcount_in < SCREEN_WIDTH) && (vcount_in < SCREEN_HEIGHT)`.
  - `active` is piped with the address.
  - `is_alive_out` is forced to 0 when the piped `active` bit is 0.
  - When not active, `rd_addr_out` still updates; its value is don't-care.
- Bank swap is a frame-boundary handshake.
  - Boundary: `hcount_in == 0 && vcount_in == SCREEN_HEIGHT` (first blanking line).
  - If `swap_req_in` is 1 at the boundary, `display_bank_out` toggles on that edge and `swap_ack_out` is 1 for exactly the next cycle.
  - `swap_req_in` is sampled only at the boundary. The producer must drop it after the ack; if it is still high at the next boundary, the bank swaps again.
  - The bank bit used for addressing is the registered `display_bank_out`, so a swap never lands mid-frame.
- Reset, asynchronous, including mid-frame: `display_bank_out=0`, `swap_ack_out=0`, `is_alive_out=0`, `hcount_out=0`, `vcount_out=0`, `rd_addr_out=0`, all pipe stages cleared. Output is valid again 4 cycles after reset release.

## Timing
- Edge k+1: `rd_addr_out`, the piped `bit`, `active`, and the counters are registered.
- Edges k+2 and k+3: RAM latency. `rd_data_in` is valid in cycle k+3, and the side-band values are delayed alongside it.
- Edge k+4: `is_alive_out = active_d & rd_data_in[bit_d]` is registered, together with `hcount_out`/`vcount_out`.
- Latency is a fixed 4 cycles, one pixel per cycle, with no stalls.
- `swap_ack_out` asserts 1 cycle after the boundary edge.

## Configuration
- `CELL_FETCH_CURSOR_EN` defined:
  - Adds inputs `cursor_x_in[6:0]` and `cursor_y_in[6:0]`.
  - Adds output `cursor_out`, which is 1 when the pixel's cell equals the cursor cell and the pixel is active.
  - `cursor_out` is aligned with `is_alive_out` (latency 4) and resets to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `life_pkg` holds:
  - `SCREEN_WIDTH`, `SCREEN_HEIGHT`, `CELL_LOG`, `WORD_W`.
  - Derived `BOARD_W`, `BOARD_H`, `ROW_W=7`, `WORDCOL_W=3`, `BOARD_ADDR_W=11`.
  - The `board_addr_t` typedef.
- Sub-module `pipe_delay`: a parameterised width × depth shift register with asynchronous reset. It is used for the counter, `active`, `bit` and cursor side-band delays.

## Test plan
- Address mapping: pixel (136,20), bank 0 → `rd_addr_out = 17` one cycle later. With `rd_data_in = 16'h0002`, `is_alive_out = 1` at cycle 4 with `hcount_out = 136`, `vcount_out = 20`.
- Bit select: hold `rd_data_in = 16'h0002`; pixels 128..143 on row 20 → `is_alive_out` is 1 only for `hcount_out` 136..143.
- Blanking: `hcount_in = 1100` with `rd_data_in = 16'hFFFF` → `is_alive_out = 0`; the same holds for `vcount_in = 770`.
- Swap: `swap_req_in = 1` at (0,768) → `display_bank_out` 0→1, a single-cycle `swap_ack_out`, and later addresses have bit 10 set. A request raised at (0,100) is ignored until (0,768).
- Reset mid-frame at pixel (500,300) → all outputs 0 immediately. After release, the first valid `is_alive_out` appears 4 cycles later and the bank is 0.
- With `CELL_FETCH_CURSOR_EN`: cursor (17,2) → `cursor_out = 1` exactly for pixels 136..143 × 16..23.

Source files
------------

// File: rtl/life_pkg.sv
// Shared board geometry, address layout and helpers for the life display path.
package life_pkg;

   localparam int SCREEN_WIDTH  = 1024;
   localparam int SCREEN_HEIGHT = 768;
   localparam int CELL_LOG      = 3;
   localparam int WORD_W        = 16;

   localparam int BOARD_W       = SCREEN_WIDTH >> CELL_LOG;
   localparam int BOARD_H       = SCREEN_HEIGHT >> CELL_LOG;
   localparam int ROW_W         = 7;
   localparam int WORDCOL_W     = 3;
   localparam int BOARD_ADDR_W  = 11;

   localparam int HCOUNT_W      = 11;
   localparam int VCOUNT_W      = 10;

   // One bank holds 1024 words; each board row occupies an 8-word stripe.
   typedef struct packed {
      logic                 bank;
      logic [ROW_W-1:0]     row;
      logic [WORDCOL_W-1:0] wordcol;
   } board_addr_t;

   function automatic board_addr_t make_board_addr(
      input logic                 bank,
      input logic [ROW_W-1:0]     row,
      input logic [WORDCOL_W-1:0] wordcol
   );
      board_addr_t a;
      a.bank    = bank;
      a.row     = row;
      a.wordcol = wordcol;
      return a;
   endfunction

endpackage

// File: rtl/cell_fetch_if.sv
// Board RAM read port plus the bank-swap handshake with the life engine.
interface cell_fetch_if;
   import life_pkg::*;

   logic [BOARD_ADDR_W-1:0] rd_addr_out;
   logic [WORD_W-1:0]       rd_data_in;
   logic                    swap_req_in;
   logic                    swap_ack_out;

   modport master (
      output rd_addr_out,
      output swap_ack_out,
      input  rd_data_in,
      input  swap_req_in
   );

   modport slave (
      input  rd_addr_out,
      input  swap_ack_out,
      output rd_data_in,
      output swap_req_in
   );

endinterface

// File: rtl/pipe_delay.sv
// Width x depth shift register with asynchronous clear, used for side-band alignment.
module pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/cell_fetch.sv
// Maps VGA pixels to board cells, reads the packed board and emits is_alive with 4-cycle aligned counters.
// Optional cursor overlay output is enabled by defining CELL_FETCH_CURSOR_EN.
module cell_fetch
   import life_pkg::*;
#(
   parameter int SCREEN_WIDTH  = life_pkg::SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = life_pkg::SCREEN_HEIGHT,
   parameter int CELL_LOG      = life_pkg::CELL_LOG,
   parameter int WORD_W        = life_pkg::WORD_W
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   cell_fetch_if.master        bus,
   output logic                display_bank_out,
   output logic                is_alive_out,
   output logic [HCOUNT_W-1:0] hcount_out,
   output logic [VCOUNT_W-1:0] vcount_out
`ifdef CELL_FETCH_CURSOR_EN
   ,
   input  logic [ROW_W-1:0]    cursor_x_in,
   input  logic [ROW_W-1:0]    cursor_y_in,
   output logic                cursor_out
`endif
);

   localparam int BIT_W  = $clog2(WORD_W);
   localparam int SIDE_W = 1 + BIT_W;
   localparam int CNT_W  = HCOUNT_W + VCOUNT_W;
   localparam logic [HCOUNT_W-1:0] LP_H_LIMIT = HCOUNT_W'(SCREEN_WIDTH);
   localparam logic [VCOUNT_W-1:0] LP_V_LIMIT = VCOUNT_W'(SCREEN_HEIGHT);

   logic [ROW_W-1:0]     w_row;
   logic [WORDCOL_W-1:0] w_wordcol;
   logic [BIT_W-1:0]     w_bit;
   logic                 w_active;
   logic                 w_boundary;
   logic                 w_swap;

   logic [SIDE_W-1:0]    w_side_d;
   logic                 w_active_d;
   logic [BIT_W-1:0]     w_bit_d;
   logic [CNT_W-1:0]     w_cnt_d;

   board_addr_t          r_addr;
   logic                 r_bank;
   logic                 r_ack;
   logic                 r_alive;

   // Cell column bits split into word column (upper) and bit-within-word (lower).
   assign w_row      = vcount_in[CELL_LOG +: ROW_W];
   assign w_wordcol  = hcount_in[CELL_LOG + BIT_W +: WORDCOL_W];
   assign w_bit      = hcount_in[CELL_LOG +: BIT_W];
   assign w_active   = (hcount_in < LP_H_LIMIT) && (vcount_in < LP_V_LIMIT);
   assign w_boundary = (hcount_in == '0) && (vcount_in == LP_V_LIMIT);
   assign w_swap     = w_boundary && bus.swap_req_in;

   // Stage 1: address issue; the bank bit is the registered select, so a swap affects only later fetches
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_addr <= '0;
         r_bank <= 1'b0;
         r_ack  <= 1'b0;
      end else begin
         r_addr <= make_board_addr(r_bank, w_row, w_wordcol);
         r_ack  <= w_swap;
         if (w_swap) begin
            r_bank <= ~r_bank;
         end
      end
   end

   // Stages 1-3: active/bit ride alongside the 2-cycle RAM read
   pipe_delay #(
      .WIDTH (SIDE_W),
      .DEPTH (3)
   ) u_side_pipe (
      .i_clk (clk_in),
      .i_rst (rst_in),
      .i_d   ({w_active, w_bit}),
      .o_q   (w_side_d)
   );

   assign w_active_d = w_side_d[SIDE_W-1];
   assign w_bit_d    = w_side_d[BIT_W-1:0];

   pipe_delay #(
      .WIDTH (CNT_W),
      .DEPTH (4)
   ) u_cnt_pipe (
      .i_clk (clk_in),
      .i_rst (rst_in),
      .i_d   ({hcount_in, vcount_in}),
      .o_q   (w_cnt_d)
   );

   // Stage 4: bit select from returned word, gated by the piped active flag
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_alive <= 1'b0;
      end else begin
         r_alive <= w_active_d & bus.rd_data_in[w_bit_d];
      end
   end

`ifdef CELL_FETCH_CURSOR_EN
   logic [HCOUNT_W-CELL_LOG-1:0] w_col;
   logic                         w_cursor_hit;

   assign w_col        = hcount_in[CELL_LOG +: HCOUNT_W-CELL_LOG];
   assign w_cursor_hit = w_active && (w_col == {1'b0, cursor_x_in}) && (w_row == cursor_y_in);

   pipe_delay #(
      .WIDTH (1),
      .DEPTH (4)
   ) u_cursor_pipe (
      .i_clk (clk_in),
      .i_rst (rst_in),
      .i_d   (w_cursor_hit),
      .o_q   (cursor_out)
   );
`endif

   assign bus.rd_addr_out  = r_addr;
   assign bus.swap_ack_out = r_ack;
   assign display_bank_out = r_bank;
   assign is_alive_out     = r_alive;
   assign hcount_out       = w_cnt_d[CNT_W-1 -: HCOUNT_W];
   assign vcount_out       = w_cnt_d[VCOUNT_W-1:0];

endmodule

// File: tb/tb_cell_fetch.sv
// Bench for cell_fetch: directed vector table, hand sequences for swap/reset, random pixels vs reference model.
module tb_cell_fetch;
   import life_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        display_bank_out;
   logic        is_alive_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   cell_fetch_if bus();

`ifdef CELL_FETCH_CURSOR_EN
   logic [6:0] cursor_x_in;
   logic [6:0] cursor_y_in;
   logic       cursor_out;
`endif

   cell_fetch dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .hcount_in        (hcount_in),
      .vcount_in        (vcount_in),
      .bus              (bus),
      .display_bank_out (display_bank_out),
      .is_alive_out     (is_alive_out),
      .hcount_out       (hcount_out),
      .vcount_out       (vcount_out)
`ifdef CELL_FETCH_CURSOR_EN
      ,
      .cursor_x_in      (cursor_x_in),
      .cursor_y_in      (cursor_y_in),
      .cursor_out       (cursor_out)
`endif
   );

   // Board RAM with a fixed 2-cycle read latency; optional fixed-word override.
   logic [15:0] mem [2048];
   logic [15:0] ram_q1;
   bit          ram_ovr;
   logic [15:0] ram_fixed;

   always @(posedge clk) begin
      ram_q1         <= mem[bus.rd_addr_out];
      bus.rd_data_in <= ram_ovr ? ram_fixed : ram_q1;
   end

   typedef struct packed {
      logic        alive;
      logic [10:0] h;
      logic [9:0]  v;
      logic        cur;
   } exp_t;

   typedef struct {
      int          h;
      int          v;
      logic [15:0] data;
      bit          exp_alive;
   } vec_t;

   exp_t q[$];
   bit   m_bank;
   int   cur_x;
   int   cur_y;
   int   checks;
   int   failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_t z;
      z = '0;
      m_bank = 1'b0;
      q.delete();
      repeat (3) q.push_back(z);
   endtask

   // Drive one pixel, advance one clock, check address/handshake now and outputs from 3 pixels earlier.
   task automatic step(input int h, input int v, input bit req);
      int          col;
      int          row;
      int          addr;
      bit          act;
      bit          bnd;
      logic [15:0] data;
      exp_t        e;
      exp_t        o;
      hcount_in         = 11'(h);
      vcount_in         = 10'(v);
      bus.swap_req_in   = req;
      act   = (h < 1024) && (v < 768);
      col   = h / 8;
      row   = v / 8;
      addr  = (m_bank ? 1024 : 0) + (row % 128) * 8 + (col / 16) % 8;
      data  = ram_ovr ? ram_fixed : mem[addr];
      e.alive = act && data[col % 16];
      e.h     = 11'(h);
      e.v     = 10'(v);
      e.cur   = act && (col == cur_x) && (row == cur_y);
      bnd   = (h == 0) && (v == 768);
      @(posedge clk);
      #1;
      if (bnd && req) m_bank = !m_bank;
      q.push_back(e);
      if (act) chk("rd_addr", bus.rd_addr_out, addr);
      chk("swap_ack", bus.swap_ack_out, bnd && req);
      chk("display_bank", display_bank_out, m_bank);
      o = q[q.size()-4];
      chk("is_alive", is_alive_out, o.alive);
      chk("hcount_out", hcount_out, o.h);
      chk("vcount_out", vcount_out, o.v);
`ifdef CELL_FETCH_CURSOR_EN
      chk("cursor_out", cursor_out, o.cur);
`endif
      if (q.size() > 4) void'(q.pop_front());
   endtask

   // Blank pixels drain in-flight reads before the RAM contents change.
   task automatic set_ram(input bit ovr, input logic [15:0] val);
      repeat (3) step(1100, 770, 1'b0);
      ram_ovr   = ovr;
      ram_fixed = val;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"}, bus.rd_addr_out, 0);
      chk({tag, "_ack"}, bus.swap_ack_out, 0);
      chk({tag, "_bank"}, display_bank_out, 0);
      chk({tag, "_alive"}, is_alive_out, 0);
      chk({tag, "_hout"}, hcount_out, 0);
      chk({tag, "_vout"}, vcount_out, 0);
`ifdef CELL_FETCH_CURSOR_EN
      chk({tag, "_cursor"}, cursor_out, 0);
`endif
   endtask

   vec_t tbl[10];

   initial begin
      checks    = 0;
      failures  = 0;
      cur_x     = 17;
      cur_y     = 2;
      ram_ovr   = 1'b1;
      ram_fixed = 16'h0000;
      for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
`ifdef CELL_FETCH_CURSOR_EN
      cursor_x_in = 7'd17;
      cursor_y_in = 7'd2;
`endif
      hcount_in       = '0;
      vcount_in       = '0;
      bus.swap_req_in = 1'b0;

      tbl[0] = '{136,  20, 16'h0002, 1'b1};
      tbl[1] = '{135,  20, 16'h0002, 1'b0};
      tbl[2] = '{143,  20, 16'h0002, 1'b1};
      tbl[3] = '{144,  20, 16'h0002, 1'b0};
      tbl[4] = '{8,     8, 16'h0002, 1'b1};
      tbl[5] = '{0,     0, 16'h0001, 1'b1};
      tbl[6] = '{1100,  20, 16'hFFFF, 1'b0};
      tbl[7] = '{100,  770, 16'hFFFF, 1'b0};
      tbl[8] = '{1023, 767, 16'hFFFF, 1'b1};
      tbl[9] = '{1024, 767, 16'hFFFF, 1'b0};

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      #2;
      rst = 1'b0;
      model_reset();

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         set_ram(1'b1, tbl[i].data);
         step(tbl[i].h, tbl[i].v, 1'b0);
         repeat (3) step(1100, 770, 1'b0);
         chk("tbl_alive", is_alive_out, tbl[i].exp_alive);
         chk("tbl_hout", hcount_out, tbl[i].h);
         chk("tbl_vout", vcount_out, tbl[i].v);
      end

      // Address mapping for (136,20) in bank 0
      set_ram(1'b1, 16'h0002);
      step(136, 20, 1'b0);
      chk("addr_136_20", bus.rd_addr_out, 17);

      // Bit select sweep across one 16-cell word
      for (int i = 0; i < 19; i++) begin
         if (i < 16) step(128 + i, 20, 1'b0);
         else        step(1100, 770, 1'b0);
         if (i >= 3) begin
            chk("bitsel_alive", is_alive_out, (128 + i - 3) >= 136);
            chk("bitsel_hout", hcount_out, 128 + i - 3);
         end
      end

      // Swap: request mid-frame is ignored until the boundary pixel
      step(0, 100, 1'b1);
      chk("early_req_ack", bus.swap_ack_out, 0);
      chk("early_req_bank", display_bank_out, 0);
      step(5, 100, 1'b1);
      step(0, 767, 1'b1);
      chk("pre_boundary_bank", display_bank_out, 0);
      step(0, 768, 1'b1);
      chk("swap_bank", display_bank_out, 1);
      chk("swap_ack_on", bus.swap_ack_out, 1);
      step(1, 768, 1'b0);
      chk("swap_ack_off", bus.swap_ack_out, 0);
      chk("swap_bank_hold", display_bank_out, 1);
      step(136, 20, 1'b0);
      chk("addr_bank1", bus.rd_addr_out, 1041);
      repeat (3) step(1100, 770, 1'b0);

      // Asynchronous reset in mid-frame
      hcount_in = 11'd500;
      vcount_in = 10'd300;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      step(136, 20, 1'b0);
      chk("post_rst_bank", display_bank_out, 0);
      chk("post_rst_addr", bus.rd_addr_out, 17);
      repeat (3) step(1100, 770, 1'b0);
      chk("post_rst_alive", is_alive_out, 1);
      chk("post_rst_hout", hcount_out, 136);
      chk("post_rst_vout", vcount_out, 20);

      // Random pixels against the reference model, board contents from memory
      set_ram(1'b0, 16'h0000);
      for (int i = 0; i < 600; i++) begin
         int h;
         int v;
         bit r;
         h = int'($urandom_range(0, 1343));
         v = int'($urandom_range(0, 805));
         r = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            h = 0;
            v = 768;
         end else if ($urandom_range(0, 9) == 0) begin
            h = 128 + int'($urandom_range(0, 23));
            v = 16 + int'($urandom_range(0, 7));
         end
         step(h, v, r);
      end
      repeat (4) step(1100, 770, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
